// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC phase generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cordic_pkg;

    localparam int WIDTH          = 32;
    localparam int FPSHIFT        = 28;
    localparam int CORDIC_LATENCY = 32;

    // round(2*pi * 2^28) and round(pi/2 * 2^28), Q4.28 radians
    localparam logic [31:0] TWO_PI_FP  = 32'h6487_ED51;
    localparam logic [31:0] HALF_PI_FP = 32'h1921_FB54;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_valid_pipe.sv
// Valid-bit delay line matching the CORDIC core's input-to-output latency.
// Latency: DEPTH cycles from vld_in to vld_out.
// Backpressure: none; shifts every cycle because the CORDIC pipeline has no enable.
//
// Ports: clk, rst (sync, active-high, clears every stage), vld_in, vld_out.
module cordic_valid_pipe #(
    parameter int DEPTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_in,
    output logic vld_out
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[DEPTH-2:0], vld_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vld_out = sr_q[DEPTH-1];

endmodule

// File: rtl/cordic_phase_gen.sv
// Burst angle generator feeding the pipelined CORDIC; angles wrapped into [0, 2*pi).
// Latency: first angle one cycle after start acceptance; result_valid LATENCY cycles after angle_valid.
// Backpressure: hold freezes issue in RUN; start is only honoured in IDLE.
//
// Ports: clk, rst (sync, active-high); start/start_phase/step/num_samples burst request;
//        hold issue stall; angle/angle_valid/wrap to the CORDIC; result_valid aligned to
//        the CORDIC outputs; busy, done (end-of-burst pulse), err (rejected-start pulse).
module cordic_phase_gen #(
    parameter int WIDTH   = cordic_pkg::WIDTH,
    parameter int FPSHIFT = cordic_pkg::FPSHIFT,
    parameter int LATENCY = cordic_pkg::CORDIC_LATENCY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] start_phase,
    input  logic [WIDTH-1:0] step,
    input  logic [15:0]      num_samples,
    input  logic             hold,
    output logic [WIDTH-1:0] angle,
    output logic             angle_valid,
    output logic             wrap,
    output logic             result_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import cordic_pkg::*;

    // The 2*pi constant is only valid for a Q4.28 angle, and the delay line needs two stages.
    if (WIDTH != 32 || FPSHIFT != 28 || LATENCY < 2) begin : g_cfg_check
        $error("cordic_phase_gen: unsupported parameter set");
    end

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(LATENCY - 1);
    localparam logic signed [WIDTH:0] TP_X = $signed((WIDTH+1)'(TWO_PI_FP));

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   phase_q, phase_d;
    logic               phase_wrap_q, phase_wrap_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [15:0]        remaining_q, remaining_d;
    logic [CW-1:0]      drain_cnt_q, drain_cnt_d;
    logic               rej_q, rej_d;
    logic [WIDTH-1:0]   angle_q, angle_d;
    logic               angle_valid_q, angle_valid_d;
    logic               wrap_q, wrap_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic signed [WIDTH:0] sum;
    logic signed [WIDTH:0] sp_x;
    logic signed [WIDTH:0] step_x;
    logic [WIDTH-1:0]      next_phase;
    logic                  next_wrap;
    logic                  start_legal;

    // Phase advance at WIDTH+1 bits so that both overflow directions are visible
    // before the single-step correction back into [0, 2*pi).
    always_comb begin
        sum        = $signed({phase_q[WIDTH-1], phase_q}) + $signed({step_q[WIDTH-1], step_q});
        next_phase = sum[WIDTH-1:0];
        next_wrap  = 1'b0;
        if (sum >= TP_X) begin
            next_phase = WIDTH'(sum - TP_X);
            next_wrap  = 1'b1;
        end else if (sum < 0) begin
            next_phase = WIDTH'(sum + TP_X);
            next_wrap  = 1'b1;
        end
    end

    always_comb begin
        sp_x        = $signed({start_phase[WIDTH-1], start_phase});
        step_x      = $signed({step[WIDTH-1], step});
        start_legal = (sp_x >= 0) && (sp_x < TP_X) && (step_x < TP_X) && (step_x > -TP_X);
    end

    // Status outputs are registered from the current state, so they trail the
    // state register by one cycle; angle/valid are registered at the issue edge.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        phase_wrap_d  = phase_wrap_q;
        step_d        = step_q;
        remaining_d   = remaining_q;
        drain_cnt_d   = drain_cnt_q;
        rej_d         = 1'b0;
        angle_d       = angle_q;
        angle_valid_d = 1'b0;
        wrap_d        = 1'b0;
        busy_d        = (state_q != IDLE);
        done_d        = (state_q == DONE);
        err_d         = rej_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        step_d       = step;
                        phase_d      = start_phase;
                        phase_wrap_d = 1'b0;
                        remaining_d  = num_samples;
                        state_d      = (num_samples == 16'd0) ? DONE : RUN;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!hold) begin
                    angle_d       = phase_q;
                    angle_valid_d = 1'b1;
                    wrap_d        = phase_wrap_q;
                    phase_d       = next_phase;
                    phase_wrap_d  = next_wrap;
                    remaining_d   = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            phase_q       <= '0;
            phase_wrap_q  <= 1'b0;
            step_q        <= '0;
            remaining_q   <= '0;
            drain_cnt_q   <= '0;
            rej_q         <= 1'b0;
            angle_q       <= '0;
            angle_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_wrap_q  <= phase_wrap_d;
            step_q        <= step_d;
            remaining_q   <= remaining_d;
            drain_cnt_q   <= drain_cnt_d;
            rej_q         <= rej_d;
            angle_q       <= angle_d;
            angle_valid_q <= angle_valid_d;
            wrap_q        <= wrap_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    cordic_valid_pipe #(
        .DEPTH (LATENCY)
    ) u_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (angle_valid_q),
        .vld_out (result_valid)
    );

    assign angle       = angle_q;
    assign angle_valid = angle_valid_q;
    assign wrap        = wrap_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_cordic_phase_gen.sv
// Directed bench for cordic_phase_gen with a queue-based scoreboard of expected events.
// Latency: n/a.
// Backpressure: hold driven from a per-burst schedule.
module tb_cordic_phase_gen;

    localparam longint TP = 64'd1686629713;
    localparam int     LAT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] start_phase;
    logic [31:0] step;
    logic [15:0] num_samples;
    logic        hold;
    logic [31:0] angle;
    logic        angle_valid;
    logic        wrap;
    logic        result_valid;
    logic        busy;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic [31:0] ang;
        logic        wr;
    } exp_ang_t;

    exp_ang_t ang_q[$];
    int       rv_q[$];
    int       done_q[$];
    int       err_q[$];

    cordic_phase_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_phase  (start_phase),
        .step         (step),
        .num_samples  (num_samples),
        .hold         (hold),
        .angle        (angle),
        .angle_valid  (angle_valid),
        .wrap         (wrap),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference phase advance: one corrective add/subtract of 2*pi.
    function automatic void adv(input longint p, input longint s, output longint n, output bit w);
        longint t;
        t = p + s;
        w = 1'b0;
        if (t >= TP) begin
            t = t - TP;
            w = 1'b1;
        end else if (t < 0) begin
            t = t + TP;
            w = 1'b1;
        end
        n = t;
    endfunction

    // Scoreboard: every DUT event must match the head of its expectation queue.
    always @(negedge clk) begin
        exp_ang_t e;
        int       c;
        if (angle_valid === 1'b1) begin
            chk("angle_valid_expected", 32'(ang_q.size() > 0), 32'd1);
            if (ang_q.size() > 0) begin
                e = ang_q.pop_front();
                chk("angle_cycle", 32'(cyc), 32'(e.cyc));
                chk("angle_value", angle, e.ang);
                chk("wrap_flag", 32'(wrap), 32'(e.wr));
            end
        end
        if (result_valid === 1'b1) begin
            chk("result_valid_expected", 32'(rv_q.size() > 0), 32'd1);
            if (rv_q.size() > 0) begin
                c = rv_q.pop_front();
                chk("result_valid_cycle", 32'(cyc), 32'(c));
            end
        end
        if (done === 1'b1) begin
            chk("done_expected", 32'(done_q.size() > 0), 32'd1);
            if (done_q.size() > 0) begin
                c = done_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(c));
            end
        end
        if (err === 1'b1) begin
            chk("err_expected", 32'(err_q.size() > 0), 32'd1);
            if (err_q.size() > 0) begin
                c = err_q.pop_front();
                chk("err_cycle", 32'(cyc), 32'(c));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_angle"}, angle, 32'd0);
        chk({tag, "_angle_valid"}, 32'(angle_valid), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap), 32'd0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_angles_left"}, 32'(ang_q.size()), 32'd0);
        chk({tag, "_results_left"}, 32'(rv_q.size()), 32'd0);
        chk({tag, "_done_left"}, 32'(done_q.size()), 32'd0);
        chk({tag, "_err_left"}, 32'(err_q.size()), 32'd0);
    endtask

    task automatic run_burst(input string tag, input logic [31:0] sp, input logic [31:0] st,
                             input int num, input int hold_after, input int hold_len,
                             input bit mid_start);
        int     t;
        int     ic;
        int     last;
        int     end_c;
        longint p;
        longint n;
        bit     w;
        bit     nw;
        exp_ang_t e;

        start_phase = sp;
        step        = st;
        num_samples = 16'(num);
        start       = 1'b1;
        t           = cyc + 1;

        p    = longint'(sp);
        w    = 1'b0;
        last = t;
        for (int i = 0; i < num; i++) begin
            ic = t + 1 + i + ((hold_len > 0 && i >= hold_after) ? hold_len : 0);
            e.cyc = ic;
            e.ang = 32'(p);
            e.wr  = w;
            ang_q.push_back(e);
            rv_q.push_back(ic + LAT);
            adv(p, longint'($signed(st)), n, nw);
            p    = n;
            w    = nw;
            last = ic;
        end
        if (num == 0) begin
            done_q.push_back(t + 1);
            end_c = t + 2;
        end else begin
            done_q.push_back(last + LAT + 1);
            end_c = last + LAT + 2;
        end

        tick();
        start = 1'b0;
        chk({tag, "_busy_at_accept"}, 32'(busy), 32'd0);

        while (cyc < end_c) begin
            if (cyc == t + 1) chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
            hold  = (hold_len > 0) && (cyc + 1 >= t + 1 + hold_after) &&
                    (cyc + 1 < t + 1 + hold_after + hold_len);
            start = mid_start && (cyc + 1 == t + 3);
            tick();
        end
        hold  = 1'b0;
        start = 1'b0;
        chk({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        check_drained(tag);
    endtask

    task automatic illegal_start(input string tag, input logic [31:0] sp, input logic [31:0] st);
        int t;
        start_phase = sp;
        step        = st;
        num_samples = 16'd3;
        start       = 1'b1;
        t           = cyc + 1;
        err_q.push_back(t + 1);
        tick();
        start = 1'b0;
        tick();
        chk({tag, "_busy_t1"}, 32'(busy), 32'd0);
        chk({tag, "_err_t1"}, 32'(err), 32'd1);
        tick();
        chk({tag, "_busy_t2"}, 32'(busy), 32'd0);
        chk({tag, "_err_t2"}, 32'(err), 32'd0);
        check_drained(tag);
    endtask

    initial begin
        int       t;
        longint   p;
        longint   n;
        bit       w;
        bit       nw;
        exp_ang_t e;

        rst         = 1'b1;
        start       = 1'b0;
        start_phase = '0;
        step        = '0;
        num_samples = '0;
        hold        = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Quarter-turn steps: the sixth angle wraps past 2*pi.
        run_burst("quarter_up", 32'd0, 32'd421657428, 6, 0, 0, 1'b0);
        // Negative step wraps below zero on the second sample.
        run_burst("quarter_down", 32'd0, 32'(-64'sd421657428), 2, 0, 0, 1'b0);
        // Single sample: valid at t+1, result at t+33, done at t+34.
        run_burst("single", 32'd123456789, 32'd1000, 1, 0, 0, 1'b0);
        // Hold gap after the second sample, plus an ignored mid-burst start.
        run_burst("hold_gap", 32'd1600000000, 32'd50000000, 8, 2, 3, 1'b1);
        // Largest legal negative step from the top of the range.
        run_burst("edge_step", 32'd1686629712, 32'(-64'sd1686629712), 3, 0, 0, 1'b0);

        illegal_start("bad_phase", 32'd1686629713, 32'd1);
        illegal_start("neg_phase", 32'hFFFF_FFFF, 32'd1);
        illegal_start("bad_step", 32'd0, 32'(-64'sd1686629713));

        run_burst("zero_len", 32'd10, 32'd20, 0, 0, 0, 1'b0);

        // Reset in DRAIN: in-flight result_valid bits must vanish.
        start_phase = 32'd0;
        step        = 32'd421657428;
        num_samples = 16'd3;
        start       = 1'b1;
        t           = cyc + 1;
        p           = 0;
        w           = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e.cyc = t + 1 + i;
            e.ang = 32'(p);
            e.wr  = w;
            ang_q.push_back(e);
            adv(p, 64'd421657428, n, nw);
            p = n;
            w = nw;
        end
        tick();
        start = 1'b0;
        while (cyc < t + 10) tick();
        chk("drain_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check_idle_outputs("drain_reset");
        rst = 1'b0;
        run_burst("after_reset", 32'd0, 32'd421657428, 3, 0, 0, 1'b0);

        repeat (4) tick();
        check_drained("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
